// File: rtl/dmem_pkg.sv
// Shared constants and address decode for the data-memory responder.
package dmem_pkg;

  localparam logic [15:0] MMIO_BASE = 16'hFF00;

  // Byte offsets of the registers inside the MMIO page
  localparam logic [3:0] OFF_GPIO  = 4'h0;
  localparam logic [3:0] OFF_CYCLE = 4'h4;
  localparam logic [3:0] OFF_TX    = 4'h8;
  localparam logic [3:0] OFF_FAULT = 4'hC;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_COUNT_LSB = 2;
  localparam int ST_OVF       = 5;

  localparam int FLT_MISALIGN = 0;
  localparam int FLT_UNMAPPED = 1;
  localparam int FLT_OVF      = 2;

  typedef enum logic [1:0] {
    REG_RAM      = 2'd0,
    REG_MMIO     = 2'd1,
    REG_UNMAPPED = 2'd2
  } region_e;

  // MMIO takes priority so a maximal RAM cannot shadow the register page
  function automatic region_e decode_region(input logic [15:0] addr, input int unsigned depth);
    int unsigned a;
    a = 32'(addr);
    if (addr[15:4] == MMIO_BASE[15:4]) return REG_MMIO;
    if (a < depth * 4) return REG_RAM;
    return REG_UNMAPPED;
  endfunction

endpackage

// File: rtl/dmem_responder_tx_fifo.sv
// Synchronous FIFO with registered pointers, zeroed head when empty and sticky overflow.
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  input  logic                     clr_ovf_i,
  output logic [W-1:0]             head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     ovf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign ovf_o   = ovf_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Fullness is judged before the edge, so a pop cannot make room for a same-cycle push
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    ovf_d    = ovf_q | (push_i && full_o);
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (clr_ovf_i) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data RAM plus MMIO page (GPIO, cycle counter, TX FIFO, fault register) for the MIPS MEM stage.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_dmM,
  input  logic [31:0] alu_out,
  input  logic [31:0] wd_dm,
  output logic [31:0] rd_dm,
  output logic [31:0] gpio_out,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        fault
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [15:0]   addr;
  logic          unused_addr_hi;
  region_e       region;
  logic          misaligned;
  logic          wr_ok, ram_we, mmio_we;
  logic [AW-1:0] ram_idx;

  logic [31:0]   ram_q [DEPTH];
  logic [31:0]   gpio_q, gpio_d;
  logic [31:0]   cycle_q, cycle_d;
  logic [1:0]    flt_q, flt_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_ovf, flt_clr;
  logic [CW-1:0] fifo_count;
  logic [31:0]   tx_status;
  logic [2:0]    flt_all;

  // Upper address half only aliases the 64 KiB space
  assign addr           = alu_out[15:0];
  assign unused_addr_hi = ^alu_out[31:16];
  assign region         = decode_region(addr, DEPTH);
  assign misaligned     = (addr[1:0] != 2'b00);
  assign ram_idx        = addr[AW+1:2];

  assign wr_ok   = we_dmM && !misaligned;
  assign ram_we  = wr_ok && (region == REG_RAM);
  assign mmio_we = wr_ok && (region == REG_MMIO);

  assign fifo_push = mmio_we && (addr[3:0] == OFF_TX);
  assign fifo_pop  = tx_valid && tx_ready;
  assign flt_clr   = mmio_we && (addr[3:0] == OFF_FAULT);

  tx_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (fifo_push),
    .data_i    (wd_dm),
    .pop_i     (fifo_pop),
    .clr_ovf_i (flt_clr),
    .head_o    (tx_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count),
    .ovf_o     (fifo_ovf)
  );

  assign tx_valid = !fifo_empty;
  assign gpio_out = gpio_q;
  assign flt_all  = {fifo_ovf, flt_q};
  assign fault    = |flt_all;

  always_comb begin
    gpio_d  = gpio_q;
    cycle_d = cycle_q + 32'd1;
    flt_d   = flt_q;
    if (mmio_we && addr[3:0] == OFF_GPIO)  gpio_d  = wd_dm;
    if (mmio_we && addr[3:0] == OFF_CYCLE) cycle_d = '0;
    // Misalignment is reported in preference to the region it would have hit
    if (flt_clr) flt_d = '0;
    else if (we_dmM && misaligned) flt_d[FLT_MISALIGN] = 1'b1;
    else if (we_dmM && region == REG_UNMAPPED) flt_d[FLT_UNMAPPED] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_q  <= '0;
      cycle_q <= '0;
      flt_q   <= '0;
    end else begin
      gpio_q  <= gpio_d;
      cycle_q <= cycle_d;
      flt_q   <= flt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && ram_we) ram_q[ram_idx] <= wd_dm;
  end

  always_comb begin
    tx_status                        = '0;
    tx_status[ST_FULL]               = fifo_full;
    tx_status[ST_EMPTY]              = fifo_empty;
    tx_status[ST_COUNT_LSB +: 3]     = 3'(fifo_count);
    tx_status[ST_OVF]                = fifo_ovf;
  end

  always_comb begin
    rd_dm = '0;
    case (region)
      REG_RAM:  rd_dm = ram_q[ram_idx];
      REG_MMIO: begin
        case (addr[3:0])
          OFF_GPIO:  rd_dm = gpio_q;
          OFF_CYCLE: rd_dm = cycle_q;
          OFF_TX:    rd_dm = tx_status;
          OFF_FAULT: rd_dm = {29'b0, flt_all};
          default:   rd_dm = '0;
        endcase
      end
      default:  rd_dm = '0;
    endcase
  end

endmodule
